// File: rtl/selector_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// selector_scan_ctrl_pkg
// Shared definitions for the selector scan controller:
//   - scan FSM state encoding
//   - channel count / data width of the downstream 4:1 selector
//   - channel walking helper (next enabled channel with wrap indication)
//   - slot masking helper used when publishing a completed frame
// -----------------------------------------------------------------------------
package selector_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 2;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DRIVE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  // Result of walking the channel mask: the channel to go to and whether the
  // walk ran past the highest enabled channel (i.e. the frame is complete).
  typedef struct packed {
    logic            wrap;
    logic [CH_W-1:0] ch;
  } next_ch_t;

  // Captured data, slot 0 (channel A) in the least significant bits.
  typedef logic [NUM_CH-1:0][DATA_W-1:0] slots_t;

  // Smallest enabled channel strictly above cur; if there is none, wrap=1 and
  // ch is the lowest enabled channel. Passing cur = 3 therefore yields the
  // lowest enabled channel, which is how a frame picks its first channel.
  function automatic next_ch_t next_enabled(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W-1:0]   cur);
    next_ch_t        res;
    logic            any_hi;
    logic            hit_hi;
    logic [CH_W-1:0] hi_ch;
    logic [CH_W-1:0] lo_ch;
    any_hi = 1'b0;
    hit_hi = 1'b0;
    hi_ch  = {CH_W{1'b0}};
    lo_ch  = {CH_W{1'b0}};
    // Descending walk: the last hit seen is the smallest matching channel.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit_hi = mask[i] && (CH_W'(i) > cur);
      hi_ch  = hit_hi ? CH_W'(i) : hi_ch;
      any_hi = any_hi | hit_hi;
      lo_ch  = mask[i] ? CH_W'(i) : lo_ch;
    end
    res.wrap = ~any_hi;
    res.ch   = any_hi ? hi_ch : lo_ch;
    return res;
  endfunction

  // Forces the slots of disabled channels to zero.
  function automatic slots_t mask_slots(input slots_t              slots,
                                        input logic [NUM_CH-1:0] mask);
    slots_t res;
    for (int i = 0; i < NUM_CH; i++) begin
      res[i] = mask[i] ? slots[i] : {DATA_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/selector_scan_ctrl_dwell_cnt.sv
// -----------------------------------------------------------------------------
// sel_dwell_cnt
// Loadable down-counter that times the settle period of each channel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear (abort)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one, saturating at zero
//   load_val   : value loaded on load
//   zero       : counter currently equals zero
// -----------------------------------------------------------------------------
module sel_dwell_cnt
  import selector_scan_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register: clear > load > decrement > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/selector_scan_ctrl.sv
// -----------------------------------------------------------------------------
// selector_scan_ctrl
// Walks the enabled channels of a downstream 4:1 2-bit selector, lets each
// channel settle for dwell+1 cycles, captures its data and publishes the whole
// frame {D,C,B,A} with a one-cycle frame_valid pulse.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a frame (IDLE only)
//   stop         : synchronous abort, highest priority
//   cont         : restart automatically after each frame
//   step_mode    : pause after every capture until step
//   step         : leave the pause
//   dwell        : extra settle cycles per channel (latched per frame)
//   chan_mask    : channel enables, bit0 = A (latched per frame)
//   Y_in         : data from the selector
//   S, EN        : selector channel select and active-low enable
//   frame_data   : last completed frame, 2 bits per slot
//   frame_valid  : one-cycle pulse when frame_data updates
//   busy         : controller is not IDLE
// -----------------------------------------------------------------------------
module selector_scan_ctrl
  import selector_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic               step_mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DATA_W-1:0]  Y_in,
  output logic [CH_W-1:0]    S,
  output logic               EN,
  output logic [7:0]         frame_data,
  output logic               frame_valid,
  output logic               busy
);

  state_e              state_r,       state_next_s;
  logic [CH_W-1:0]     s_r,           s_next_s;
  logic                en_r,          en_next_s;
  slots_t              slots_r,       slots_next_s;
  slots_t              frame_data_r,  frame_data_next_s;
  logic                frame_valid_r, frame_valid_next_s;
  logic                busy_r,        busy_next_s;
  logic [NUM_CH-1:0]   mask_r,        mask_next_s;
  logic [DWELL_W-1:0]  dwell_r,       dwell_next_s;

  logic                cnt_clr_s;
  logic                cnt_load_s;
  logic                cnt_dec_s;
  logic [DWELL_W-1:0]  cnt_load_val_s;
  logic                cnt_zero_s;
  logic                advance_s;
  next_ch_t            adv_s;
  next_ch_t            first_live_s;

  // Next channel within the latched frame, and the first channel of a frame
  // that would start from the live inputs (start or continuous restart).
  assign adv_s        = next_enabled(mask_r, s_r);
  assign first_live_s = next_enabled(chan_mask, 2'b11);

  sel_dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (cnt_load_val_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, datapath and counter control for the scan FSM.
  always_comb begin
    state_next_s       = state_r;
    s_next_s           = s_r;
    en_next_s          = en_r;
    slots_next_s       = slots_r;
    frame_data_next_s  = frame_data_r;
    frame_valid_next_s = 1'b0;
    mask_next_s        = mask_r;
    dwell_next_s       = dwell_r;
    cnt_clr_s          = 1'b0;
    cnt_load_s         = 1'b0;
    cnt_dec_s          = 1'b0;
    cnt_load_val_s     = dwell_r;
    advance_s          = 1'b0;

    if (stop) begin
      // Abort: the partial frame is dropped, published frame is untouched.
      state_next_s = ST_IDLE;
      s_next_s     = 2'b00;
      en_next_s    = 1'b1;
      slots_next_s = {(NUM_CH*DATA_W){1'b0}};
      cnt_clr_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          s_next_s  = 2'b00;
          en_next_s = 1'b1;
          if (start && (chan_mask != 4'b0000)) begin
            state_next_s   = ST_DRIVE;
            s_next_s       = first_live_s.ch;
            en_next_s      = 1'b0;
            mask_next_s    = chan_mask;
            dwell_next_s   = dwell;
            slots_next_s   = {(NUM_CH*DATA_W){1'b0}};
            cnt_load_s     = 1'b1;
            cnt_load_val_s = dwell;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (cnt_zero_s) begin
            state_next_s = ST_CAPTURE;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
        ST_CAPTURE: begin
          slots_next_s[s_r] = Y_in;
          if (step_mode) begin
            state_next_s = ST_HOLD;
          end else begin
            advance_s = 1'b1;
          end
        end
        ST_HOLD: begin
          if (step) begin
            advance_s = 1'b1;
          end else begin
            state_next_s = ST_HOLD;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          s_next_s     = 2'b00;
          en_next_s    = 1'b1;
          cnt_clr_s    = 1'b1;
        end
      endcase

      // Leaving a channel: go to the next one, or publish the frame. The
      // publish uses slots_next_s so a capture in this same cycle is included.
      if (advance_s) begin
        if (!adv_s.wrap) begin
          state_next_s   = ST_DRIVE;
          s_next_s       = adv_s.ch;
          en_next_s      = 1'b0;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = dwell_r;
        end else begin
          frame_data_next_s  = mask_slots(slots_next_s, mask_r);
          frame_valid_next_s = 1'b1;
          if (cont && (chan_mask != 4'b0000)) begin
            state_next_s   = ST_DRIVE;
            s_next_s       = first_live_s.ch;
            en_next_s      = 1'b0;
            mask_next_s    = chan_mask;
            dwell_next_s   = dwell;
            slots_next_s   = {(NUM_CH*DATA_W){1'b0}};
            cnt_load_s     = 1'b1;
            cnt_load_val_s = dwell;
          end else begin
            state_next_s = ST_IDLE;
            s_next_s     = 2'b00;
            en_next_s    = 1'b1;
          end
        end
      end else begin
        frame_valid_next_s = 1'b0;
      end
    end

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      s_r           <= 2'b00;
      en_r          <= 1'b1;
      slots_r       <= {(NUM_CH*DATA_W){1'b0}};
      frame_data_r  <= {(NUM_CH*DATA_W){1'b0}};
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      mask_r        <= {NUM_CH{1'b0}};
      dwell_r       <= {DWELL_W{1'b0}};
    end else begin
      state_r       <= state_next_s;
      s_r           <= s_next_s;
      en_r          <= en_next_s;
      slots_r       <= slots_next_s;
      frame_data_r  <= frame_data_next_s;
      frame_valid_r <= frame_valid_next_s;
      busy_r        <= busy_next_s;
      mask_r        <= mask_next_s;
      dwell_r       <= dwell_next_s;
    end
  end

  assign S           = s_r;
  assign EN          = en_r;
  assign frame_data  = frame_data_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

endmodule

// File: doc/selector_scan_ctrl.md
SELECTOR_SCAN_CTRL -- requirements
Module: selector_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the dwell-count input.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge system clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a scan frame; sampled in IDLE only.
REQ-006 stop  in  1  synchronous abort; takes priority over every other input.
REQ-007 cont  in  1  1 = restart the frame automatically; 0 = single frame.
REQ-008 step_mode  in  1  1 = pause after every capture until a step pulse arrives.
REQ-009 step  in  1  one-cycle pulse that advances from HOLD.
REQ-010 dwell  in  DWELL_W  extra settle cycles per channel; latched at start.
REQ-011 chan_mask  in  4  channel enables, bit0=A … bit3=D; latched at start.
REQ-012 Y_in  in  2  data returned by the downstream 4:1 2-bit selector.
REQ-013 S  out  2  channel select driven to the selector.
REQ-014 EN  out  1  selector enable, active-low: 0 passes data, 1 disables.
REQ-015 frame_data  out  8  captured frame {D,C,B,A}, 2 bits per slot.
REQ-016 frame_valid  out  1  one-cycle pulse when frame_data is updated.
REQ-017 busy  out  1  high in every state other than IDLE.

Function
REQ-018 States: IDLE, DRIVE, CAPTURE, HOLD.
REQ-019 IDLE behaviour:
- start=1 and latched-mask≠0 → DRIVE next cycle.
- S = lowest enabled channel; EN = 0; dwell counter loaded with dwell.
REQ-020 start with chan_mask=0 is ignored; the block stays in IDLE.
REQ-021 start while busy is ignored.
REQ-022 DRIVE lasts dwell+1 cycles:
- counter decrements each cycle;
- counter==0 → CAPTURE.
REQ-023 CAPTURE (one cycle): slot[S] <= Y_in; EN stays 0.
REQ-024 Next-state from CAPTURE:
- step_mode=1 → HOLD.
- otherwise → advance directly.
REQ-025 HOLD: keeps S and EN=0 until step=1, then advances.
REQ-026 Advance: S moves to the next enabled channel in ascending order.
REQ-027 Advance when the current channel is the highest enabled channel:
- frame_data <= all slots; frame_valid=1 next cycle.
- cont=1 → DRIVE on the lowest enabled channel with dwell reloaded.
- cont=0 → IDLE.
REQ-028 Masked channels' slots read 2'b00 in frame_data.
REQ-029 frame_valid is registered and never high for two consecutive cycles unless consecutive frames complete in consecutive cycles, which is impossible given REQ-022.
REQ-030 stop=1 in any state:
- IDLE next cycle; S=2'b00; EN=1.
- no frame_valid; frame_data keeps its last value; partial slots discarded.
REQ-031 stop and start in the same cycle: stop wins.
REQ-032 In IDLE, S=2'b00 and EN=1.
REQ-033 dwell and chan_mask changes mid-frame have no effect until the next start or cont restart.

Reset
REQ-034 On rst=1, asynchronously:
- state=IDLE; S=2'b00; EN=1; frame_data=8'h00; frame_valid=0; busy=0.
- slots and dwell counter cleared.
REQ-035 Reset mid-frame discards the frame with no frame_valid.
REQ-036 Operation resumes on the first clk edge after rst falls.

Structure
REQ-037 Shared package contents:
- state encoding enum (IDLE, DRIVE, CAPTURE, HOLD);
- NUM_CH=4; DATA_W=2;
- helper function next_enabled(mask, cur) returning the next channel and a wrap flag.
REQ-038 Sub-module: one, sel_dwell_cnt (loadable down-counter with zero flag); everything else inline.

Verification
REQ-039 Bench setup: model the selector as A=00, B=01, C=10, D=11 (Y=0 when EN=1).
REQ-040 Full frame: mask=1111, dwell=2, cont=0, start in cycle 0:
- S=0,1,2,3 for 4 cycles each;
- frame_valid in cycle 17 with frame_data=8'hE4;
- back in IDLE with EN=1.
REQ-041 Sparse mask: mask=1010, dwell=0:
- S visits only 1 and 3;
- frame_data=8'hC4.
REQ-042 Zero mask and busy start:
- mask=0000 with start → busy stays 0, EN stays 1.
- a second start mid-frame → no change in the S sequence.
REQ-043 Step mode: step_mode=1, mask=0011:
- held at S=0 with EN=0 until step;
- frame_valid only after the second step.
REQ-044 Stop mid-DRIVE of channel 2:
- IDLE next cycle, S=00, EN=1;
- no frame_valid; frame_data still holds the prior 8'hE4.
REQ-045 Continuous mode plus async reset:
- cont=1 → frame_valid pulses every 16 cycles for dwell=2.
- rst asserted mid-frame → outputs at reset values immediately, without waiting for clk.
